// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_pkg
// Brief   : State encoding and default limits shared by the memory arbiter.
// Revision: 1.0
// ============================================================================
package mem_arbiter_pkg;

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_BUSY_I = 2'd1;
   localparam logic [1:0] c_BUSY_D = 2'd2;

   localparam int c_STARVE_LIMIT_DFLT = 4;
   localparam int c_TIMEOUT_DFLT      = 255;

endpackage
`default_nettype wire

// File: rtl/arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : arb_watchdog
// Brief   : Counts stalled BUSY cycles; expired marks the cycle that reaches TIMEOUT.
// Revision: 1.0
// ============================================================================
module arb_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int             c_W      = $clog2(TIMEOUT + 1);
   localparam int             c_LAST_I = TIMEOUT - 1;
   localparam logic [c_W-1:0] c_MAX    = TIMEOUT[c_W-1:0];
   localparam logic [c_W-1:0] c_LAST   = c_LAST_I[c_W-1:0];

   logic [c_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_count <= '0;
      end else if (count_en && (r_count != c_MAX)) begin
         r_count <= r_count + 1'b1;
      end
   end

   // Asserted on the stalled cycle whose increment lands on TIMEOUT.
   assign expired = count_en & (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Two-port (fetch/data) single-memory arbiter with starvation guard.
// Revision: 1.0
// ============================================================================
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = c_STARVE_LIMIT_DFLT,
   parameter int TIMEOUT      = c_TIMEOUT_DFLT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic        err,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   localparam int              c_SW   = $clog2(STARVE_LIMIT + 1);
   localparam logic [c_SW-1:0] c_SMAX = STARVE_LIMIT[c_SW-1:0];

   logic [1:0]      r_state;
   logic [c_SW-1:0] r_starve;
   logic            r_mem_req, r_mem_we, r_if_done, r_d_done, r_err;
   logic [31:0]     r_mem_addr, r_mem_wdata, r_if_rdata, r_d_rdata;

   logic w_idle, w_busy, w_starved, w_grant_i, w_grant_d;
   logic w_i_misal, w_d_misal, w_wd_clear, w_wd_en, w_expired;

   assign w_idle    = (r_state == c_IDLE);
   assign w_busy    = (r_state == c_BUSY_I) || (r_state == c_BUSY_D);
   assign w_starved = (r_starve == c_SMAX);
   assign w_i_misal = (if_addr[1:0] != 2'b00);
   assign w_d_misal = (d_addr[1:0] != 2'b00);

   // A port finishing this cycle is still holding its request; skip it.
   assign w_grant_i = w_idle & if_req & ~r_if_done & (~(d_req & ~r_d_done) | w_starved);
   assign w_grant_d = w_idle & d_req & ~r_d_done & ~w_grant_i;

   assign w_wd_clear = (w_grant_i & ~w_i_misal) | (w_grant_d & ~w_d_misal);
   assign w_wd_en    = w_busy & ~mem_ready;

   arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .clear    (w_wd_clear),
      .count_en (w_wd_en),
      .expired  (w_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= c_IDLE;
         r_starve    <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_done   <= 1'b0;
         r_d_done    <= 1'b0;
         r_err       <= 1'b0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
      end else begin
         r_if_done <= 1'b0;
         r_d_done  <= 1'b0;
         r_err     <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (w_grant_i) begin
                  if (w_i_misal) begin
                     r_if_done  <= 1'b1;
                     r_err      <= 1'b1;
                     r_if_rdata <= '0;
                  end else begin
                     r_state     <= c_BUSY_I;
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= 1'b0;
                     r_mem_addr  <= if_addr;
                     r_mem_wdata <= '0;
                     r_starve    <= '0;
                  end
               end else if (w_grant_d) begin
                  if (w_d_misal) begin
                     r_d_done  <= 1'b1;
                     r_err     <= 1'b1;
                     r_d_rdata <= '0;
                  end else begin
                     r_state     <= c_BUSY_D;
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= d_we;
                     r_mem_addr  <= d_addr;
                     r_mem_wdata <= d_wdata;
                     if (if_req && !w_starved) begin
                        r_starve <= r_starve + 1'b1;
                     end
                  end
               end
            end
            c_BUSY_I, c_BUSY_D: begin
               // Ready wins over a simultaneous watchdog expiry.
               if (mem_ready || w_expired) begin
                  r_state   <= c_IDLE;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_err     <= ~mem_ready;
                  if (r_state == c_BUSY_I) begin
                     r_if_done  <= 1'b1;
                     r_if_rdata <= mem_ready ? mem_rdata : 32'h0;
                  end else begin
                     r_d_done <= 1'b1;
                     if (!mem_ready) begin
                        r_d_rdata <= '0;
                     end else if (!r_mem_we) begin
                        r_d_rdata <= mem_rdata;
                     end
                  end
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign if_done   = r_if_done;
   assign d_done    = r_d_done;
   assign err       = r_err;
   assign if_rdata  = r_if_rdata;
   assign d_rdata   = r_d_rdata;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign stall     = (if_req & ~r_if_done) | (d_req & ~r_d_done);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Self-checking bench for mem_arbiter: vector table plus scoreboard.
// Revision: 1.0
// ============================================================================
module tb_mem_arbiter;

   localparam int c_NEVER = 1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_we, mem_ready;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic        if_done, d_done, err, stall, mem_req, mem_we;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

   always #5 clk = ~clk;

   mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(255)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata), .err(err), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   typedef struct {
      bit          f;
      bit          err;
      bit          chk;
      logic [31:0] rdata;
   } exp_t;

   typedef struct {
      bit          f;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrd;
      int          dly;
      int          lat;
   } vec_t;

   exp_t        q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          resp_delay = 0;
   logic [31:0] resp_data = 32'h0;
   bit          idle_ready = 1'b0;
   int          busy_cnt = 0;
   logic [31:0] m_if, m_d;
   bit          m_if_v, m_d_v;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input bit f, input bit e_err, input bit e_chk, input logic [31:0] rd);
      exp_t e;
      e.f = f; e.err = e_err; e.chk = e_chk; e.rdata = rd;
      q.push_back(e);
   endtask

   // Memory model: ready after resp_delay BUSY cycles; drives mem_ready in IDLE on request.
   initial begin
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_req) begin
            mem_ready = (busy_cnt == resp_delay);
            mem_rdata = mem_ready ? resp_data : 32'h0;
            busy_cnt++;
         end else begin
            mem_ready = idle_ready;
            mem_rdata = idle_ready ? 32'hBAD0BAD0 : 32'h0;
            busy_cnt  = 0;
         end
      end
   end

   // Scoreboard: every done pulse consumes the oldest expected completion.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (if_done || d_done)) begin
         chk("done_exclusive", {31'b0, if_done & d_done}, 32'h0);
         chk("sb_pending", {31'b0, q.size() != 0}, 32'h1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("sb_port_is_fetch", {31'b0, if_done}, {31'b0, e.f});
            chk("sb_err", {31'b0, err}, {31'b0, e.err});
            if (e.chk) chk("sb_rdata", e.f ? if_rdata : d_rdata, e.rdata);
         end
      end else if (!rst && err) begin
         chk("err_without_done", {31'b0, err}, 32'h0);
      end
   end

   task automatic txn(input vec_t v, input string nm);
      int          lat;
      bit          done, mis, tmo;
      logic [31:0] erd;
      bit          echk;
      mis  = (v.addr[1:0] != 2'b00);
      tmo  = (v.dly >= c_NEVER);
      echk = 1'b1;
      erd  = 32'h0;
      if (mis) begin
         echk = 1'b0;
         if (v.f) m_if_v = 1'b0; else m_d_v = 1'b0;
      end else if (tmo) begin
         if (v.f) begin m_if = 32'h0; m_if_v = 1'b1; end
         else begin m_d = 32'h0; m_d_v = 1'b1; end
      end else if (v.f) begin
         erd = v.mrd; m_if = v.mrd; m_if_v = 1'b1;
      end else if (!v.we) begin
         erd = v.mrd; m_d = v.mrd; m_d_v = 1'b1;
      end else begin
         erd = m_d; echk = m_d_v;
      end
      push_exp(v.f, mis | tmo, echk, erd);
      resp_delay = v.dly;
      resp_data  = v.mrd;
      if (v.f) begin
         if_addr = v.addr; if_req = 1'b1;
      end else begin
         d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_req = 1'b1;
      end
      lat  = 0;
      done = 1'b0;
      while (!done && lat < 400) begin
         step();
         lat++;
         if (lat == 1) begin
            chk({nm, "_mem_req"}, {31'b0, mem_req}, {31'b0, ~mis});
            if (!mis) begin
               chk({nm, "_mem_addr"}, mem_addr, v.addr);
               chk({nm, "_mem_we"}, {31'b0, mem_we}, {31'b0, v.we & ~v.f});
               if (!v.f) chk({nm, "_mem_wdata"}, mem_wdata, v.wdata);
            end
         end
         done = v.f ? if_done : d_done;
      end
      chk({nm, "_latency"}, lat, v.lat);
      if_req = 1'b0;
      d_req  = 1'b0;
      #1;
      chk({nm, "_stall_off"}, {31'b0, stall}, 32'h0);
      step();
   endtask

   initial begin
      vec_t v[7];
      vec_t tv;

      #200000;
      $display("FAIL global_time_limit: bench did not finish");
      $fatal(1);
   end

   initial begin
      vec_t v[7];
      vec_t tv;

      rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
      m_if = 32'h0; m_d = 32'h0; m_if_v = 1'b1; m_d_v = 1'b1;
      repeat (3) step();
      chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_if_done", {31'b0, if_done}, 32'h0);
      chk("rst_d_done", {31'b0, d_done}, 32'h0);
      chk("rst_err", {31'b0, err}, 32'h0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'h0);
      rst = 1'b0;
      step();

      //          f  we addr          wdata         mrd           dly lat
      v[0] = '{1'b0, 1'b0, 32'h10,  32'h0,        32'h30000033, 0, 2};
      v[1] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'h00000013, 0, 2};
      v[2] = '{1'b0, 1'b0, 32'h24,  32'h0,        32'h0000A5A5, 1, 3};
      v[3] = '{1'b0, 1'b1, 32'h20,  32'hDEADBEEF, 32'h77777777, 3, 5};
      v[4] = '{1'b1, 1'b0, 32'h104, 32'h0,        32'h00001234, 2, 4};
      v[5] = '{1'b0, 1'b0, 32'h13,  32'h0,        32'h0,        0, 1};
      v[6] = '{1'b1, 1'b0, 32'h102, 32'h0,        32'h0,        0, 1};
      for (int i = 0; i < 7; i++) txn(v[i], $sformatf("vec%0d", i));

      // Store that never sees mem_ready: 255 stalled BUSY cycles, abort on the last.
      tv = '{1'b0, 1'b1, 32'h20, 32'h0BADCAFE, 32'h0, c_NEVER, 256};
      txn(tv, "timeout");
      chk("timeout_mem_req_low", {31'b0, mem_req}, 32'h0);

      // Simultaneous requests: data first, fetch granted in the data done cycle.
      push_exp(1'b0, 1'b0, 1'b1, 32'h00000055);
      push_exp(1'b1, 1'b0, 1'b1, 32'h00000066);
      m_d = 32'h55; m_if = 32'h66;
      resp_delay = 0; resp_data = 32'h55;
      if_addr = 32'h200; d_addr = 32'h30; d_we = 1'b0;
      if_req = 1'b1; d_req = 1'b1;
      #1;
      chk("cont_stall_0", {31'b0, stall}, 32'h1);
      step();
      chk("cont_first_addr", mem_addr, 32'h30);
      chk("cont_stall_1", {31'b0, stall}, 32'h1);
      step();
      chk("cont_d_done", {31'b0, d_done}, 32'h1);
      d_req = 1'b0; resp_data = 32'h66;
      #1;
      chk("cont_stall_2", {31'b0, stall}, 32'h1);
      step();
      chk("cont_second_req", {31'b0, mem_req}, 32'h1);
      chk("cont_second_addr", mem_addr, 32'h200);
      chk("cont_stall_3", {31'b0, stall}, 32'h1);
      step();
      chk("cont_if_done", {31'b0, if_done}, 32'h1);
      if_req = 1'b0;
      #1;
      chk("cont_stall_off", {31'b0, stall}, 32'h0);
      step();

      // Starvation: both requests rise together each round; the fifth round goes to fetch.
      resp_delay = 0; if_addr = 32'h300; d_we = 1'b0;
      for (int r = 0; r < 6; r++) begin
         bit          ef;
         logic [31:0] es;
         ef = (r == 4);
         es = (r < 4) ? r + 1 : ((r == 4) ? 0 : 1);
         d_addr    = 32'h40 + 4 * r;
         resp_data = 32'h1000 + r;
         push_exp(ef, 1'b0, 1'b1, 32'h1000 + r);
         if (ef) m_if = 32'h1000 + r; else m_d = 32'h1000 + r;
         if_req = 1'b1; d_req = 1'b1;
         step();
         chk($sformatf("starve%0d_req", r), {31'b0, mem_req}, 32'h1);
         chk($sformatf("starve%0d_addr", r), mem_addr, ef ? 32'h300 : d_addr);
         chk($sformatf("starve%0d_count", r), {29'b0, dut.r_starve}, es);
         step();
         chk($sformatf("starve%0d_done", r), {31'b0, ef ? if_done : d_done}, 32'h1);
         if_req = 1'b0; d_req = 1'b0;
         step();
      end

      // Reset during BUSY_I, then mem_ready while idle: no completion may appear.
      resp_delay = c_NEVER; if_addr = 32'h400; if_req = 1'b1;
      step();
      chk("rstbusy_mem_req", {31'b0, mem_req}, 32'h1);
      step();
      rst = 1'b1; if_req = 1'b0;
      step();
      chk("rstbusy_mem_req_clr", {31'b0, mem_req}, 32'h0);
      chk("rstbusy_mem_addr_clr", mem_addr, 32'h0);
      chk("rstbusy_if_rdata_clr", if_rdata, 32'h0);
      rst = 1'b0; idle_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("rstbusy_no_done%0d", k), {31'b0, if_done | d_done | err}, 32'h0);
         chk($sformatf("rstbusy_idle%0d", k), {31'b0, mem_req}, 32'h0);
      end
      idle_ready = 1'b0;

      repeat (3) step();
      chk("sb_drained", q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
